// File: rtl/cfg_bus_initiator_pkg.sv
// Shared types for the config-bus initiator.
//   state_t : FSM encoding (IDLE / REQ / WAIT / DRAIN)
//   op_t    : recorded operation type with OP_WR / OP_RD values
package cfg_bus_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef logic op_t;

  localparam op_t OP_WR = 1'b0;
  localparam op_t OP_RD = 1'b1;

  // Next-cycle busy indication for a given next state.
  function automatic logic busy_for(input state_t st);
    return (st != ST_IDLE);
  endfunction

endpackage

// File: rtl/cfg_bus_initiator.sv
// Controller-side initiator for the cross-domain config handshake.
// Turns single-pulse bus read/write requests into a one-cycle strobe towards
// the clock-domain synchroniser, holds address/data stable, waits for the
// synchroniser ack and returns ack/rdata/err to the bus master. A timeout
// followed by a drain phase keeps the bus from hanging while guaranteeing a
// late ack is never credited to a later request.
//
// Ports:
//   clk_i, rstn_i          controller clock, async active-low reset
//   sys_addr_i/sys_wdata_i bus address / write data, valid with wen/ren
//   sys_wen_i/sys_ren_i    single-cycle write / read request
//   sys_rdata_o            read data, valid with sys_ack_o (held until next ack)
//   sys_ack_o/sys_err_o    one-cycle completion pulse and its error qualifier
//   ctrl_addr_o/ctrl_wdata_o latched address / write data to register domain
//   ctrl_we_o/ctrl_re_o    one-cycle write / read strobe to synchroniser
//   ctrl_ack_i/ctrl_rdata_i synchroniser ack pulse and read data
//   busy_o                 high whenever the FSM is not idle
//   overrun_o              sticky: a request arrived while one was in flight
module cfg_bus_initiator
  import cfg_bus_initiator_pkg::*;
#(
  parameter int unsigned AW      = 20,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [AW-1:0] sys_addr_i,
  input  logic [DW-1:0] sys_wdata_i,
  input  logic          sys_wen_i,
  input  logic          sys_ren_i,
  output logic [DW-1:0] sys_rdata_o,
  output logic          sys_ack_o,
  output logic          sys_err_o,
  output logic [AW-1:0] ctrl_addr_o,
  output logic [DW-1:0] ctrl_wdata_o,
  output logic          ctrl_we_o,
  output logic          ctrl_re_o,
  input  logic          ctrl_ack_i,
  input  logic [DW-1:0] ctrl_rdata_i,
  output logic          busy_o,
  output logic          overrun_o
);

  localparam int unsigned CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned LIMIT  = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam bit          TO_EN  = (TIMEOUT > 0);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  op_t             op_q, op_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            we_q, we_d;
  logic            re_q, re_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;
  logic            req;
  logic            limit_hit;

  assign req       = sys_wen_i | sys_ren_i;
  assign limit_hit = TO_EN && (cnt_q == CW'(LIMIT));

  // State and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_WR;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state and next-output logic. Every output is registered, so the
  // values computed here appear one cycle later (e.g. the strobe is set on
  // the IDLE->REQ transition and is therefore visible exactly in REQ).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    overrun_d = overrun_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = sys_addr_i;
          state_d = ST_REQ;
          // Write wins over a simultaneous read; the read is silently dropped.
          if (sys_wen_i) begin
            wdata_d = sys_wdata_i;
            op_d    = OP_WR;
            we_d    = 1'b1;
          end else begin
            op_d    = OP_RD;
            re_d    = 1'b1;
          end
        end
      end

      ST_REQ: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
        if (req) overrun_d = 1'b1;
      end

      ST_WAIT: begin
        if (req) overrun_d = 1'b1;
        // An ack arriving on the limit cycle still counts as a completion.
        if (ctrl_ack_i) begin
          ack_d   = 1'b1;
          rdata_d = (op_q == OP_RD) ? ctrl_rdata_i : '0;
          state_d = ST_IDLE;
        end else if (limit_hit) begin
          ack_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DRAIN: begin
        // Requests here are refused with an error rather than forwarded, so
        // the outstanding late ack cannot be matched to them.
        if (req) begin
          ack_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end
        if (ctrl_ack_i) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = busy_for(state_d);
  end

  assign sys_rdata_o  = rdata_q;
  assign sys_ack_o    = ack_q;
  assign sys_err_o    = err_q;
  assign ctrl_addr_o  = addr_q;
  assign ctrl_wdata_o = wdata_q;
  assign ctrl_we_o    = we_q;
  assign ctrl_re_o    = re_q;
  assign busy_o       = busy_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_cfg_bus_initiator.sv
// Self-checking bench for cfg_bus_initiator (TIMEOUT = 8). Expected
// completions are queued when stimulus is driven and compared when the DUT
// raises sys_ack_o.
module tb_cfg_bus_initiator;

  localparam int unsigned AW      = 20;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 8;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic [AW-1:0] sys_addr_i;
  logic [DW-1:0] sys_wdata_i;
  logic          sys_wen_i;
  logic          sys_ren_i;
  logic [DW-1:0] sys_rdata_o;
  logic          sys_ack_o;
  logic          sys_err_o;
  logic [AW-1:0] ctrl_addr_o;
  logic [DW-1:0] ctrl_wdata_o;
  logic          ctrl_we_o;
  logic          ctrl_re_o;
  logic          ctrl_ack_i;
  logic [DW-1:0] ctrl_rdata_i;
  logic          busy_o;
  logic          overrun_o;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   we_cnt  = 0;
  int   re_cnt  = 0;
  int   exp_we  = 0;
  int   exp_re  = 0;

  cfg_bus_initiator #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .sys_addr_i   (sys_addr_i),
    .sys_wdata_i  (sys_wdata_i),
    .sys_wen_i    (sys_wen_i),
    .sys_ren_i    (sys_ren_i),
    .sys_rdata_o  (sys_rdata_o),
    .sys_ack_o    (sys_ack_o),
    .sys_err_o    (sys_err_o),
    .ctrl_addr_o  (ctrl_addr_o),
    .ctrl_wdata_o (ctrl_wdata_o),
    .ctrl_we_o    (ctrl_we_o),
    .ctrl_re_o    (ctrl_re_o),
    .ctrl_ack_i   (ctrl_ack_i),
    .ctrl_rdata_i (ctrl_rdata_i),
    .busy_o       (busy_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_i);
  endtask

  // Drive a one-cycle request; returns in the cycle after it was sampled.
  task automatic drive_req(input logic wen, input logic ren,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data);
    sys_wen_i   = wen;
    sys_ren_i   = ren;
    sys_addr_i  = addr;
    sys_wdata_i = data;
    tick();
    sys_wen_i   = 1'b0;
    sys_ren_i   = 1'b0;
    sys_addr_i  = '0;
    sys_wdata_i = '0;
  endtask

  task automatic drive_ack(input logic [DW-1:0] data);
    ctrl_ack_i   = 1'b1;
    ctrl_rdata_i = data;
    tick();
    ctrl_ack_i   = 1'b0;
    ctrl_rdata_i = '0;
  endtask

  task automatic push_exp(input logic err, input logic [DW-1:0] rdata);
    exp_t e;
    e.err   = err;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Monitor: count strobes and score every completion against the queue.
  always @(negedge clk_i) begin
    if (rstn_i) begin
      if (ctrl_we_o) we_cnt++;
      if (ctrl_re_o) re_cnt++;
      if (sys_ack_o) begin
        check_val("sb_pending", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check_val("ack_err", 64'(sys_err_o), 64'(mon_e.err));
          check_val("ack_rdata", 64'(sys_rdata_o), 64'(mon_e.rdata));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn_i       = 1'b0;
    sys_addr_i   = '0;
    sys_wdata_i  = '0;
    sys_wen_i    = 1'b0;
    sys_ren_i    = 1'b0;
    ctrl_ack_i   = 1'b0;
    ctrl_rdata_i = '0;
    tick(2);
    check_val("rst_ack",    64'(sys_ack_o),   64'd0);
    check_val("rst_busy",   64'(busy_o),      64'd0);
    check_val("rst_strobe", 64'({ctrl_we_o, ctrl_re_o}), 64'd0);
    check_val("rst_addr",   64'(ctrl_addr_o), 64'd0);
    rstn_i = 1'b1;
    tick();

    // Write, ack 6 cycles after the strobe; ack rdata must be zeroed.
    drive_req(1'b1, 1'b0, 20'h00010, 32'hDEADBEEF);
    exp_we++;
    check_val("wr_we",    64'(ctrl_we_o),    64'd1);
    check_val("wr_re",    64'(ctrl_re_o),    64'd0);
    check_val("wr_addr",  64'(ctrl_addr_o),  64'h00010);
    check_val("wr_wdata", 64'(ctrl_wdata_o), 64'hDEADBEEF);
    check_val("wr_busy",  64'(busy_o),       64'd1);
    tick();
    check_val("wr_we_pulse", 64'(ctrl_we_o), 64'd0);
    tick(5);
    check_val("wr_no_early_ack", 64'(sys_ack_o), 64'd0);
    push_exp(1'b0, '0);
    drive_ack(32'h5A5A5A5A);
    check_val("wr_ack",   64'(sys_ack_o), 64'd1);
    check_val("wr_idle",  64'(busy_o),    64'd0);
    tick();
    check_val("wr_ack_pulse", 64'(sys_ack_o), 64'd0);

    // Read returning data.
    drive_req(1'b0, 1'b1, 20'h00ABC, 32'h0);
    exp_re++;
    check_val("rd_re", 64'(ctrl_re_o), 64'd1);
    check_val("rd_we", 64'(ctrl_we_o), 64'd0);
    tick(2);
    push_exp(1'b0, 32'h12345678);
    drive_ack(32'h12345678);
    check_val("rd_ack", 64'(sys_ack_o), 64'd1);
    tick();
    check_val("rd_hold", 64'(sys_rdata_o), 64'h12345678);

    // Timeout: error ack on the 9th cycle after the strobe, then drain.
    drive_req(1'b0, 1'b1, 20'h00200, 32'h0);
    exp_re++;
    push_exp(1'b1, '0);
    tick(8);
    check_val("to_not_yet", 64'(sys_ack_o), 64'd0);
    tick();
    check_val("to_ack",  64'(sys_ack_o), 64'd1);
    check_val("to_err",  64'(sys_err_o), 64'd1);
    tick();
    check_val("to_drain_busy", 64'(busy_o),    64'd1);
    check_val("to_ack_pulse",  64'(sys_ack_o), 64'd0);
    drive_ack(32'hAAAA5555);
    check_val("to_late_idle",  64'(busy_o),      64'd0);
    check_val("to_late_noack", 64'(sys_ack_o),   64'd0);
    check_val("to_late_rdata", 64'(sys_rdata_o), 64'd0);

    // Request during DRAIN is refused with an error and not forwarded.
    drive_req(1'b0, 1'b1, 20'h00300, 32'h0);
    exp_re++;
    push_exp(1'b1, '0);
    tick(10);
    check_val("dr_in_drain", 64'(busy_o), 64'd1);
    push_exp(1'b1, '0);
    drive_req(1'b0, 1'b1, 20'h00400, 32'h0);
    check_val("dr_ack",  64'(sys_ack_o),  64'd1);
    check_val("dr_err",  64'(sys_err_o),  64'd1);
    check_val("dr_re",   64'(ctrl_re_o),  64'd0);
    check_val("dr_addr", 64'(ctrl_addr_o), 64'h00300);
    drive_ack(32'h0);
    check_val("dr_idle", 64'(busy_o), 64'd0);

    // Simultaneous wen+ren, then a protocol-violating write during WAIT.
    drive_req(1'b1, 1'b1, 20'h00500, 32'hCAFEF00D);
    exp_we++;
    check_val("sim_we", 64'(ctrl_we_o), 64'd1);
    check_val("sim_re", 64'(ctrl_re_o), 64'd0);
    tick();
    check_val("ovr_clear", 64'(overrun_o), 64'd0);
    drive_req(1'b1, 1'b0, 20'h00600, 32'h11111111);
    check_val("ovr_set",   64'(overrun_o),    64'd1);
    check_val("ovr_we",    64'(ctrl_we_o),    64'd0);
    check_val("ovr_addr",  64'(ctrl_addr_o),  64'h00500);
    check_val("ovr_wdata", 64'(ctrl_wdata_o), 64'hCAFEF00D);
    tick();
    push_exp(1'b0, '0);
    drive_ack(32'h0);
    check_val("ovr_ack", 64'(sys_ack_o), 64'd1);
    tick(3);
    check_val("ovr_sticky", 64'(overrun_o), 64'd1);

    // Reset during WAIT clears everything immediately; no ack for it.
    drive_req(1'b0, 1'b1, 20'h00700, 32'h0);
    exp_re++;
    tick(2);
    rstn_i = 1'b0;
    #1;
    check_val("mr_busy",    64'(busy_o),      64'd0);
    check_val("mr_overrun", 64'(overrun_o),   64'd0);
    check_val("mr_addr",    64'(ctrl_addr_o), 64'd0);
    check_val("mr_wdata",   64'(ctrl_wdata_o), 64'd0);
    check_val("mr_outs",    64'({sys_ack_o, sys_err_o, ctrl_we_o, ctrl_re_o}), 64'd0);
    tick();
    rstn_i = 1'b1;
    tick(12);
    drive_req(1'b0, 1'b1, 20'h00800, 32'h0);
    exp_re++;
    check_val("post_rst_re", 64'(ctrl_re_o), 64'd1);
    tick();
    push_exp(1'b0, 32'h0BADCAFE);
    drive_ack(32'h0BADCAFE);
    check_val("post_rst_ack", 64'(sys_ack_o), 64'd1);
    tick(3);

    check_val("we_count", 64'(we_cnt),    64'(exp_we));
    check_val("re_count", 64'(re_cnt),    64'(exp_re));
    check_val("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
